instr_issuer: RTL and testbench
===============================

// Module: instr_issuer
// PURPOSE
//  Issue side of the decoder start/done handshake. Queues instruction requests
//  (opcode, rD, rA, immediate) and packs each into a 32-bit Type-B word.
//  Drives one instruction at a time into a decoder FSM such as the ADDIK
//  decoder: holds Instruction, pulses start, waits for done.
//  Sits between the array sequencer and the per-opcode decoders.
// PARAMETERS
//  QDEPTH   4   request FIFO depth; power of 2, >=2
//  TIMEOUT  15  max WAIT cycles for done before abort; 1..255
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   FIFO not full; push when valid&&ready
//  req_opcode   in   6   major opcode, e.g. 6'b001100 ADDIK
//  req_rD       in   5   destination register
//  req_rA       in   5   source register
//  req_imm      in   32  immediate; [31:16] used only under IMM_PREFIX_EN
//  Instruction  out  32  [0:31], bit 0 = MSB; [0:5] op, [6:10] rD, [11:15] rA, [16:31] imm
//  start        out  1   one-cycle issue strobe
//  done         in   1   decoder completion
//  busy         out  1   FSM not IDLE, or FIFO not empty
//  timeout_err  out  1   sticky; set on timeout, cleared only by reset
//  issued_count out  8   completed issues, wraps 255->0
// BEHAVIOUR
//  Reset values: all outputs 0 except req_ready=1. FIFO empty, FSM IDLE.
//  Reset mid-operation drops all queued and in-flight work at once; no done expected.
//  FIFO: registered, no fall-through; ptr wrap mod QDEPTH.
//   req_ready = !full; a push when full is impossible.
//   Push and pop in the same cycle are both honoured; count is unchanged.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE:  if FIFO non-empty, pop the head, load the Instruction register, go to ISSUE.
//   ISSUE: start=1 for exactly 1 cycle; go to WAIT; done in ISSUE is ignored.
//   WAIT:  on done, issued_count++ and go to IDLE.
//          After TIMEOUT WAIT cycles without done: set timeout_err, drop the entry, go to IDLE.
//   done in IDLE is ignored.
//  Instruction stays stable from ISSUE through the cycle done is seen; it holds afterwards.
//  Latency: push at cycle N -> start=1 at N+2. With a decoder answering done at N+3,
//   the next start comes at N+5 at the earliest, so throughput is 1 per 3 cycles.
//  start, busy and timeout_err are registered outputs.
// CONFIGURATION
//  IMM_PREFIX_EN defined:
//   FIFO entry carries all 32 imm bits.
//   If req_imm[31:16] != {16{req_imm[15]}}, the issuer first issues the prefix
//    word {6'b101100,5'd0,5'd0,req_imm[31:16]} with a full start/done handshake.
//    It then issues the main word with imm[15:0].
//   FSM adds PFX_ISSUE and PFX_WAIT ahead of ISSUE.
//   A timeout in PFX_WAIT aborts both words; issued_count counts each word.
//  IMM_PREFIX_EN undefined:
//   req_imm[31:16] is ignored; no prefix is ever emitted.
// STRUCTURE
//  Package instr_issuer_pkg holds:
//   opcode constants OP_ADDIK=6'b001100 and OP_IMM=6'b101100
//   field slice localparams
//   state encoding constants
//   function pack_typeb(op,rd,ra,imm16)
//  Sub-module issue_fifo(WIDTH,DEPTH) holds the request queue.
//  instr_issuer holds the FSM, timeout counter and Instruction register.
// TESTING
//  1. Single ADDIK op=001100, rD=3, rA=5, imm=0x0010; decoder answers done 1 cycle after start.
//     -> Instruction=0x30650010, start high for 1 cycle at N+2, issued_count=1.
//  2. Push 5 requests back-to-back with QDEPTH=4 and the decoder stalled.
//     -> req_ready drops after the FIFO fills.
//     -> all 5 are issued in order once done flows; issued_count=5.
//  3. Decoder never answers done.
//     -> timeout_err=1 after 15 WAIT cycles; FSM returns to IDLE and the next entry issues.
//  4. Assert reset while in WAIT with 2 entries queued.
//     -> start=0, busy=0, FIFO empty and count 0 immediately, without waiting for a clock edge.
//  5. IMM_PREFIX_EN, imm=0x12348000.
//     -> prefix 0xB0001234 issues, then the main word with imm16=0x8000; issued_count +2.
//     -> with imm=0xFFFF8000, no prefix is issued.
//  6. done pulses while IDLE, and done pulses during ISSUE.
//     -> both are ignored; issued_count is unchanged.

Source files
------------

// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: opcodes, Type-B field layout,
// FSM state encoding and the Type-B packing helper.
// Optional feature macro: IMM_PREFIX_EN (32-bit immediates via an IMM prefix word).
package instr_issuer_pkg;

    localparam logic [5:0] OP_ADDIK = 6'b001100;
    localparam logic [5:0] OP_IMM   = 6'b101100;

    // Type-B field positions, numbered LSB = 0 (document bit 0 is our bit 31)
    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned RD_HI  = 25;
    localparam int unsigned RD_LO  = 21;
    localparam int unsigned RA_HI  = 20;
    localparam int unsigned RA_LO  = 16;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIssue    = 3'd1,
        StWait     = 3'd2,
        StPfxIssue = 3'd3,
        StPfxWait  = 3'd4
    } state_e;

    function automatic logic [31:0] pack_typeb(input logic [5:0]  op,
                                               input logic [4:0]  rd,
                                               input logic [4:0]  ra,
                                               input logic [15:0] imm16);
        logic [31:0] w;
        w                = '0;
        w[OP_HI:OP_LO]   = op;
        w[RD_HI:RD_LO]   = rd;
        w[RA_HI:RA_LO]   = ra;
        w[IMM_HI:IMM_LO] = imm16;
        return w;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Registered request queue for the instruction issuer (no fall-through).
// Push and pop in the same cycle are both honoured. Feature macro of the
// enclosing design (IMM_PREFIX_EN) only changes WIDTH, not this logic.
module issue_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; DEPTH is a power of 2 so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array, written on accepted push; contents need no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer/occupancy registers, cleared asynchronously to drop queued work
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Issue side of the decoder start/done handshake: queues requests, packs each
// into a Type-B word, pulses start and waits for done (with timeout).
// Optional feature macro: IMM_PREFIX_EN -- immediates that do not fit in a
// sign-extended 16 bits are preceded by an IMM prefix word.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [4:0]  req_rD,
    input  logic [4:0]  req_rA,
    input  logic [31:0] req_imm,
    output logic [31:0] Instruction,  // MSB is document bit 0
    output logic        start,
    input  logic        done,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  issued_count
);

`ifdef IMM_PREFIX_EN
    localparam int unsigned ImmW = 32;
`else
    localparam int unsigned ImmW = 16;
`endif
    localparam int unsigned EntryW  = 16 + ImmW;
    localparam int unsigned CW      = $clog2(QDEPTH + 1);
    localparam logic [7:0]  TmoLast = 8'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [7:0]         count_q, count_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    logic [EntryW-1:0]  fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty, fifo_pop, push_ok;
    logic [CW-1:0]      fifo_cnt, fifo_cnt_nxt;
    logic [5:0]         head_op;
    logic [4:0]         head_rd, head_ra;
    logic [ImmW-1:0]    head_imm;
    logic [31:0]        head_word;

`ifdef IMM_PREFIX_EN
    logic [31:0]        main_q, main_d;
`else
    logic [15:0]        unused_imm_hi;
    assign unused_imm_hi = req_imm[31:16];
`endif

    assign req_ready  = !fifo_full;
    assign push_ok    = req_valid && !fifo_full;
    assign fifo_wdata = {req_opcode, req_rD, req_rA, req_imm[ImmW-1:0]};

    assign head_imm  = fifo_rdata[ImmW-1:0];
    assign head_ra   = fifo_rdata[ImmW+4:ImmW];
    assign head_rd   = fifo_rdata[ImmW+9:ImmW+5];
    assign head_op   = fifo_rdata[ImmW+15:ImmW+10];
    assign head_word = pack_typeb(head_op, head_rd, head_ra, head_imm[15:0]);

    issue_fifo #(
        .WIDTH (EntryW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_ok),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Issue FSM next-state: pop/load in idle, strobe start, wait for done or timeout
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        tmo_d    = tmo_q;
        count_d  = count_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
`ifdef IMM_PREFIX_EN
        main_d   = main_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
`ifdef IMM_PREFIX_EN
                    if (head_imm[31:16] != {16{head_imm[15]}}) begin
                        instr_d = pack_typeb(OP_IMM, 5'd0, 5'd0, head_imm[31:16]);
                        main_d  = head_word;
                        state_d = StPfxIssue;
                    end else begin
                        instr_d = head_word;
                        state_d = StIssue;
                    end
`else
                    instr_d = head_word;
                    state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    count_d = count_q + 8'd1;
                    state_d = StIdle;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
`ifdef IMM_PREFIX_EN
            StPfxIssue: begin
                tmo_d   = '0;
                state_d = StPfxWait;
            end
            StPfxWait: begin
                if (done) begin
                    count_d = count_q + 8'd1;
                    instr_d = main_q;
                    state_d = StIssue;
                end else if (tmo_q == TmoLast) begin
                    // Abandon both words of the pair
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are derived from next-state so they align with the state
    always_comb begin
        fifo_cnt_nxt = fifo_cnt + CW'(push_ok) - CW'(fifo_pop);
        start_d      = (state_d == StIssue) || (state_d == StPfxIssue);
        busy_d       = (state_d != StIdle) || (fifo_cnt_nxt != '0);
    end

    // State and output registers, asynchronously cleared so reset drops all work
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= '0;
            tmo_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef IMM_PREFIX_EN
            main_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
`ifdef IMM_PREFIX_EN
            main_q  <= main_d;
`endif
        end
    end

    assign Instruction  = instr_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign timeout_err  = err_q;
    assign issued_count = count_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer (QDEPTH=4, TIMEOUT=15).
// Honors IMM_PREFIX_EN for the immediate-prefix expectations.
module tb_instr_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        done = 1'b0;
    logic [5:0]  req_opcode = '0;
    logic [4:0]  req_rD = '0;
    logic [4:0]  req_rA = '0;
    logic [31:0] req_imm = '0;
    logic        req_ready, start, busy, timeout_err;
    logic [31:0] Instruction;
    logic [7:0]  issued_count;

    int n_chk = 0;
    int n_fail = 0;

    // Expected Type-B words for ADDIK rD=1..5, rA=0, imm=1..5
    logic [31:0] exp2 [5] = '{32'h30200001, 32'h30400002, 32'h30600003,
                              32'h30800004, 32'h30A00005};

    always #5 clk = ~clk;

    instr_issuer #(
        .QDEPTH  (4),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_rD       (req_rD),
        .req_rA       (req_rA),
        .req_imm      (req_imm),
        .Instruction  (Instruction),
        .start        (start),
        .done         (done),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .issued_count (issued_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
                        input logic [31:0] imm);
        req_valid  = 1'b1;
        req_opcode = op;
        req_rD     = rd;
        req_rA     = ra;
        req_imm    = imm;
        step();
        req_valid  = 1'b0;
    endtask

    // Wait (bounded) for start, check the word, then answer done one cycle later
    task automatic serve(input string tag, input logic [31:0] exp_instr);
        int k = 0;
        while (start !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        chk({tag, "_instr"}, Instruction, exp_instr);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        int seen;

        // Reset values
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_count", {24'd0, issued_count}, 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // 1: single ADDIK, latency and one-cycle start
        push(6'b001100, 5'd3, 5'd5, 32'h0000_0010);
        chk("t1_start_n1", {31'd0, start}, 32'd0);
        chk("t1_busy_n1", {31'd0, busy}, 32'd1);
        step();
        chk("t1_start_n2", {31'd0, start}, 32'd1);
        chk("t1_instr", Instruction, 32'h3065_0010);
        step();
        chk("t1_start_n3", {31'd0, start}, 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t1_count", {24'd0, issued_count}, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_instr_hold", Instruction, 32'h3065_0010);

        // 2: five back-to-back pushes, decoder stalled; FIFO fills
        for (int i = 0; i < 5; i++) begin
            req_valid  = 1'b1;
            req_opcode = 6'b001100;
            req_rD     = 5'(i + 1);
            req_rA     = 5'd0;
            req_imm    = 32'(i + 1);
            chk("t2_ready", {31'd0, req_ready}, 32'd1);
            chk("t2_start", {31'd0, start}, (i == 2) ? 32'd1 : 32'd0);
            step();
        end
        req_valid = 1'b0;
        chk("t2_full", {31'd0, req_ready}, 32'd0);
        chk("t2_instr0", Instruction, exp2[0]);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 1; i < 5; i++) serve($sformatf("t2_e%0d", i), exp2[i]);
        chk("t2_count", {24'd0, issued_count}, 32'd6);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // 3: decoder never answers; timeout after 15 WAIT cycles, next entry issues
        push(6'b001100, 5'd6, 5'd0, 32'h0000_00AA);
        push(6'b001100, 5'd7, 5'd0, 32'h0000_00BB);
        chk("t3_start_a", {31'd0, start}, 32'd1);
        chk("t3_instr_a", Instruction, 32'h30C0_00AA);
        repeat (15) step();
        chk("t3_err_before", {31'd0, timeout_err}, 32'd0);
        chk("t3_instr_stable", Instruction, 32'h30C0_00AA);
        step();
        chk("t3_err_set", {31'd0, timeout_err}, 32'd1);
        chk("t3_count_kept", {24'd0, issued_count}, 32'd6);
        step();
        chk("t3_start_b", {31'd0, start}, 32'd1);
        chk("t3_instr_b", Instruction, 32'h30E0_00BB);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t3_count_b", {24'd0, issued_count}, 32'd7);
        chk("t3_err_sticky", {31'd0, timeout_err}, 32'd1);

        // 6: done while IDLE and during ISSUE is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t6_idle_done", {24'd0, issued_count}, 32'd7);
        chk("t6_idle_nostart", {31'd0, start}, 32'd0);
        push(6'b001100, 5'd8, 5'd0, 32'h0000_00CC);
        step();
        chk("t6_start", {31'd0, start}, 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t6_issue_done", {24'd0, issued_count}, 32'd7);
        step();
        step();
        chk("t6_still_wait", {24'd0, issued_count}, 32'd7);
        chk("t6_instr", Instruction, 32'h3100_00CC);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t6_count", {24'd0, issued_count}, 32'd8);

        // 5: wide immediate, then one that sign-extends from 16 bits
        push(6'b001100, 5'd1, 5'd2, 32'h1234_8000);
`ifdef IMM_PREFIX_EN
        serve("t5_pfx", 32'hB000_1234);
        serve("t5_main", 32'h3022_8000);
        chk("t5_count", {24'd0, issued_count}, 32'd10);
`else
        serve("t5_main", 32'h3022_8000);
        chk("t5_count", {24'd0, issued_count}, 32'd9);
`endif
        push(6'b001100, 5'd1, 5'd2, 32'hFFFF_8000);
        serve("t5_nopfx", 32'h3022_8000);
`ifdef IMM_PREFIX_EN
        chk("t5_count2", {24'd0, issued_count}, 32'd11);
`else
        chk("t5_count2", {24'd0, issued_count}, 32'd10);
`endif

        // 4: reset in WAIT with two entries queued clears everything at once
        push(6'b001100, 5'd1, 5'd0, 32'h0000_0001);
        push(6'b001100, 5'd2, 5'd0, 32'h0000_0002);
        push(6'b001100, 5'd3, 5'd0, 32'h0000_0003);
        chk("t4_busy_pre", {31'd0, busy}, 32'd1);
        chk("t4_instr_pre", Instruction, 32'h3020_0001);
        reset = 1'b1;
        #1;
        chk("t4_start", {31'd0, start}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ready", {31'd0, req_ready}, 32'd1);
        chk("t4_count", {24'd0, issued_count}, 32'd0);
        chk("t4_err", {31'd0, timeout_err}, 32'd0);
        #2;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            step();
            if (start !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("t4_no_reissue", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
